// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: turns LSB loads/stores and 4-byte instruction
// fetches into single-byte accesses on the 8-bit RAM/IO bus.
module mem_ctrl #(
  parameter int         ADDR_W    = 32,
  parameter logic [1:0] IO_PREFIX = 2'b11
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              rob_clear_up,
  input  logic              lsb_visit_mem,
  input  logic              work_type,
  input  logic [2:0]        word_size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       data_in,
  output logic              cache_ready,
  output logic              is_load,
  output logic [31:0]       data_out,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [31:0]       if_data,
  input  logic              io_buffer_full,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
);
  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2} state_t;

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        n_q, n_d;
  logic              zext_q, zext_d;
  logic              fetch_q, fetch_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       buf_q, buf_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [7:0]        mem_dout_q, mem_dout_d;
  logic              mem_wr_q, mem_wr_d;
  logic              cache_ready_q, cache_ready_d;
  logic              is_load_q, is_load_d;
  logic [31:0]       data_out_q, data_out_d;
  logic              if_ready_q, if_ready_d;
  logic [31:0]       if_data_q, if_data_d;

  logic [2:0]  n_req;
  logic [2:0]  last_idx;
  logic        io_blocked;
  logic        can_accept;
  logic [31:0] shifted;
  logic [31:0] ext;

  always_comb begin
    case (word_size[1:0])
      2'd0:    n_req = 3'd1;
      2'd1:    n_req = 3'd2;
      default: n_req = 3'd4;
    endcase
  end

  // A waiting IO store holds the bus for the LSB, so fetches stay blocked too.
  assign io_blocked = !work_type && (addr[17:16] == IO_PREFIX) && io_buffer_full;
  assign can_accept = !cache_ready_q && !if_ready_q && !rob_clear_up;
  assign last_idx   = n_q - 3'd1;
  // Read bytes shift in from the top, so an N-byte value ends up in the top N bytes.
  assign shifted    = {mem_din, buf_q[31:8]};

  always_comb begin
    case (n_q)
      3'd1:    ext = zext_q ? {24'd0, shifted[31:24]} : {{24{shifted[31]}}, shifted[31:24]};
      3'd2:    ext = zext_q ? {16'd0, shifted[31:16]} : {{16{shifted[31]}}, shifted[31:16]};
      default: ext = shifted;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    n_d           = n_q;
    zext_d        = zext_q;
    fetch_d       = fetch_q;
    wdata_d       = wdata_q;
    buf_d         = buf_q;
    mem_a_d       = mem_a_q;
    mem_dout_d    = mem_dout_q;
    mem_wr_d      = 1'b0;
    cache_ready_d = 1'b0;
    is_load_d     = is_load_q;
    data_out_d    = data_out_q;
    if_ready_d    = 1'b0;
    if_data_d     = if_data_q;
    case (state_q)
      IDLE: begin
        if (can_accept) begin
          if (lsb_visit_mem) begin
            if (!io_blocked) begin
              mem_a_d = addr;
              n_d     = n_req;
              zext_d  = word_size[2];
              fetch_d = 1'b0;
              wdata_d = data_in;
              cnt_d   = 3'd0;
              if (work_type) begin
                state_d = RD;
              end else begin
                state_d    = WR;
                mem_wr_d   = 1'b1;
                mem_dout_d = data_in[7:0];
              end
            end
          end else if (if_req) begin
            mem_a_d = if_addr;
            n_d     = 3'd4;
            zext_d  = 1'b0;
            fetch_d = 1'b1;
            cnt_d   = 3'd0;
            state_d = RD;
          end
        end
      end
      RD: begin
        if (rob_clear_up) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q < last_idx) mem_a_d = mem_a_q + ONE;
          // cnt_q counts cycles since the first address; byte cnt_q-1 arrives now.
          if (cnt_q != 3'd0) buf_d = shifted;
          if (cnt_q == n_q) begin
            state_d = IDLE;
            if (fetch_q) begin
              if_ready_d = 1'b1;
              if_data_d  = shifted;
            end else begin
              cache_ready_d = 1'b1;
              is_load_d     = 1'b1;
              data_out_d    = ext;
            end
          end
        end
      end
      WR: begin
        // A store in flight is already committed, so a flush does not stop it.
        if (cnt_q == last_idx) begin
          state_d       = IDLE;
          cache_ready_d = 1'b1;
          is_load_d     = 1'b0;
        end else begin
          cnt_d      = cnt_q + 3'd1;
          mem_a_d    = mem_a_q + ONE;
          mem_dout_d = wdata_q[15:8];
          wdata_d    = {8'd0, wdata_q[31:8]};
          mem_wr_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q       <= IDLE;
      cnt_q         <= 3'd0;
      n_q           <= 3'd0;
      zext_q        <= 1'b0;
      fetch_q       <= 1'b0;
      wdata_q       <= 32'd0;
      buf_q         <= 32'd0;
      mem_a_q       <= '0;
      mem_dout_q    <= 8'd0;
      mem_wr_q      <= 1'b0;
      cache_ready_q <= 1'b0;
      is_load_q     <= 1'b0;
      data_out_q    <= 32'd0;
      if_ready_q    <= 1'b0;
      if_data_q     <= 32'd0;
    end else if (rdy_in) begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      n_q           <= n_d;
      zext_q        <= zext_d;
      fetch_q       <= fetch_d;
      wdata_q       <= wdata_d;
      buf_q         <= buf_d;
      mem_a_q       <= mem_a_d;
      mem_dout_q    <= mem_dout_d;
      mem_wr_q      <= mem_wr_d;
      cache_ready_q <= cache_ready_d;
      is_load_q     <= is_load_d;
      data_out_q    <= data_out_d;
      if_ready_q    <= if_ready_d;
      if_data_q     <= if_data_d;
    end
  end

  assign cache_ready = cache_ready_q;
  assign is_load     = is_load_q;
  assign data_out    = data_out_q;
  assign if_ready    = if_ready_q;
  assign if_data     = if_data_q;
  assign mem_dout    = mem_dout_q;
  assign mem_a       = mem_a_q;
  // A frozen cycle must never repeat the pending write.
  assign mem_wr      = mem_wr_q & rdy_in;
endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Responder end of the LSB memory request interface; also serves the instruction-fetch unit.
- Converts each LSB load/store request, and each 4-byte instruction-fetch request, into byte-serial accesses on the 8-bit RAM/IO bus.
- Returns load data with a one-cycle completion pulse.
- Sits between Lsb/IFetch and the external RAM port.

Parameters:
- ADDR_W, 32, address width of requests and of mem_a.
- IO_PREFIX, 2'b11, value of addr[17:16] that marks an IO address.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous active-high reset
- rdy_in  input  1  global enable; all state frozen when low
- rob_clear_up  input  1  misprediction flush
- lsb_visit_mem  input  1  LSB request valid (level, held until cache_ready)
- work_type  input  1  1=load, 0=store
- word_size  input  3  [1:0]: 0=1B, 1=2B, 2=4B; [2]=1 zero-extend, 0 sign-extend (loads only)
- addr  input  ADDR_W  LSB byte address
- data_in  input  32  store data, low bytes used
- cache_ready  output  1  one-cycle LSB completion pulse
- is_load  output  1  qualifies cache_ready: completed op was a load
- data_out  output  32  extended load data, valid while cache_ready=1
- if_req  input  1  fetch request valid (level)
- if_addr  input  ADDR_W  fetch address
- if_ready  output  1  one-cycle fetch completion pulse
- if_data  output  32  fetched word, little-endian
- io_buffer_full  input  1  IO write buffer full
- mem_din  input  8  RAM read byte
- mem_dout  output  8  RAM write byte
- mem_a  output  ADDR_W  RAM byte address
- mem_wr  output  1  1=write, 0=read

Behaviour:
- Reset (async, rst_in=1): state=IDLE, counters 0; cache_ready, is_load, data_out, if_ready, if_data, mem_dout, mem_a, mem_wr all 0.
- rdy_in=0: all registers hold. Exception: mem_wr forced 0 combinationally, so a stalled cycle never repeats a write.
- States:
  - IDLE: no bus activity, mem_wr=0.
  - RD: LSB load or fetch.
  - WR: LSB store.
- IDLE acceptance:
  - No request is accepted in a cycle where cache_ready or if_ready is 1. This prevents re-accepting a request the requester is still dropping.
  - Otherwise lsb_visit_mem has priority over if_req.
  - An LSB store with addr[17:16]==IO_PREFIX is not accepted while io_buffer_full=1. While it waits, the fetch stays blocked.
  - On acceptance the controller latches the address, size, extend mode, data and source (LSB/IF).
  - N = 1/2/4 for word_size[1:0] = 0/1/2; fetches use N=4. word_size[1:0]=3 is treated as 4B.
- Bus timing (registered; A = acceptance cycle):
  - Byte j (0..N-1) has mem_a = base+j in cycle A+1+j.
  - Stores: mem_wr=1 and mem_dout = data_in[8j+7:8j] in the same cycle.
  - Loads: mem_din for byte j is sampled at the end of cycle A+2+j (1-cycle RAM latency). mem_a may run one address past the last byte with mem_wr=0; that read is harmless.
- Completion:
  - Load: cache_ready=1, is_load=1 in cycle A+2+N, so a word load completes at A+6 and a byte load at A+3.
  - Store: cache_ready=1, is_load=0 in cycle A+1+N (word A+5, byte A+2); data_out holds its previous value.
  - Fetch: if_ready=1 in cycle A+6 with if_data = {b3,b2,b1,b0}.
  - The controller returns to IDLE on the same edge that raises the pulse. Pulses last exactly one cycle.
- Extension: 1B/2B loads are sign-extended from bit 7/15 when word_size[2]=0, zero-extended when word_size[2]=1. 4B loads pass through unchanged.
- Address arithmetic: modulo 2^ADDR_W; no alignment checks.
- rob_clear_up=1 (with rdy_in=1):
  - RD (load or fetch): abort at the next edge to IDLE, mem_wr=0, no completion pulse.
  - WR: continue until all bytes are written and still pulse cache_ready (the store was committed).
  - IDLE: nothing is accepted in that cycle.
- Reset mid-operation: immediate return to IDLE with all outputs 0; any partial store is abandoned.

Test Plan:
- Word load: RAM[0x100..0x103]=78,56,34,12; lsb_visit_mem=1, work_type=1, word_size=2, addr=0x100 -> mem_a=0x100..0x103 in A+1..A+4; cache_ready=1, is_load=1, data_out=0x12345678 at A+6; single pulse; no re-accept in A+6.
- Sign/zero extension: RAM[0x200]=0x80 -> word_size=0 gives 0xFFFFFF80 at A+3; word_size=4 gives 0x00000080. Halfword 0x8001 at 0x202 with word_size=1 gives 0xFFFF8001.
- Store: word_size=1, addr=0x300, data_in=0xAABBCCDD -> mem_wr=1 with (0x300,DD) then (0x301,CC); cache_ready=1, is_load=0 at A+3; RAM[0x302] unchanged.
- Arbitration plus fetch: lsb_visit_mem and if_req raised in the same cycle -> LSB served first; fetch accepted after the LSB pulse cycle; if_ready with correct little-endian if_data 6 cycles after its acceptance.
- IO backpressure: store to 0x30000 with io_buffer_full=1 for 5 cycles -> no mem_wr during those cycles; write issued after the buffer clears; cache_ready 2 cycles after acceptance.
- Flush/stall: rob_clear_up during a word load at A+3 -> no cache_ready, IDLE next cycle. rob_clear_up during a word store -> all 4 bytes still written. rdy_in=0 mid-store -> mem_wr=0 and no duplicated byte.
